// File: rtl/ir_encoder_pkg.sv
// Shared datatypes for the RV32 instruction encoder: instruction-type codes,
// major opcodes, output FIFO state and the sign-extension range helper.
package ir_encoder_pkg;

   typedef enum logic [2:0] {
      INSTR_R   = 3'd0,
      INSTR_I   = 3'd1,
      INSTR_S   = 3'd2,
      INSTR_B   = 3'd3,
      INSTR_U   = 3'd4,
      INSTR_J   = 3'd5,
      INSTR_ERR = 3'd7
   } instr_type_e;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LD     = 7'b0000011;
   localparam logic [6:0] OP_ST     = 7'b0100011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_ECSR   = 7'b1110011;

   typedef enum logic [1:0] {
      FIFO_EMPTY = 2'd0,
      FIFO_ONE   = 2'd1,
      FIFO_FULL  = 2'd2
   } fifo_state_e;

   typedef struct packed {
      logic [31:0] ir;
      logic        err;
   } fifo_entry_t;

   // True when bits 31:msb of v are all equal, i.e. v fits a (msb+1)-bit signed field.
   function automatic logic sext_ok(input logic [31:0] v, input int unsigned msb);
      logic [31:0] hi;
      hi = 32'($signed(v) >>> msb);
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/ir_encoder_if.sv
// Field-bundle input and packed-word output handshakes of the instruction encoder.
interface ir_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  instr_type;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] immediate;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_ir;
   logic        out_err;

   modport master (
      output in_valid, instr_type, opcode, rd, rs1, rs2, funct3, funct7, immediate, out_ready,
      input  in_ready, out_valid, out_ir, out_err
   );

   modport slave (
      input  in_valid, instr_type, opcode, rd, rs1, rs2, funct3, funct7, immediate, out_ready,
      output in_ready, out_valid, out_ir, out_err
   );
endinterface

// File: rtl/ir_encoder_imm_pack_32.sv
// Places a decoder-format immediate into its instruction bit slots (all other
// bits zero) and flags immediates the slots cannot represent.
module imm_pack_32
   import ir_encoder_pkg::*;
(
   input  logic [2:0]  instr_type_i,
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [31:0] imm_i,
   output logic [31:0] imm_slots_o,
   output logic        imm_err_o
);

   logic is_shift;
   assign is_shift = (opcode_i == OP_ALUI) && ((funct3_i == 3'b001) || (funct3_i == 3'b101));

   always_comb begin
      imm_slots_o = '0;
      imm_err_o   = 1'b0;
      case (instr_type_i)
         INSTR_I: begin
            // Shifts carry funct7 in the upper immediate bits and a 5-bit shamt.
            if (is_shift) begin
               imm_slots_o = {funct7_i, imm_i[4:0], 20'b0};
               imm_err_o   = |imm_i[31:5];
            end else begin
               imm_slots_o = {imm_i[11:0], 20'b0};
               imm_err_o   = !sext_ok(imm_i, 11);
            end
         end
         INSTR_S: begin
            imm_slots_o = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
            imm_err_o   = !sext_ok(imm_i, 11);
         end
         INSTR_B: begin
            imm_slots_o = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
            imm_err_o   = !sext_ok(imm_i, 12) || imm_i[0];
         end
         INSTR_U: begin
            imm_slots_o = {imm_i[31:12], 12'b0};
            imm_err_o   = |imm_i[11:0];
         end
         INSTR_J: begin
            imm_slots_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
            imm_err_o   = !sext_ok(imm_i, 20) || imm_i[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ir_encoder.sv
// RV32 instruction encoder with a 2-entry output FIFO and saturating counters.
// Define IR_ENCODER_CHECK_EN to enable type/opcode/immediate error checking.
//
// state      | meaning
// FIFO_EMPTY | no word buffered, out_valid low
// FIFO_ONE   | head holds one word
// FIFO_FULL  | head and tail hold words, in_ready low
module ir_encoder
   import ir_encoder_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst,
   ir_encoder_if.slave      bus,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   fifo_state_e      state_q, state_d;
   fifo_entry_t      head_q, head_d, tail_q, tail_d, new_entry;
   logic             in_ready_q, out_valid, push, pop;
   logic [CNT_W-1:0] enc_q, enc_d, err_q, err_d;
   logic [31:0]      imm_slots, raw_word;
   logic             imm_err, new_err;

   imm_pack_32 u_imm_pack (
      .instr_type_i (bus.instr_type),
      .opcode_i     (bus.opcode),
      .funct3_i     (bus.funct3),
      .funct7_i     (bus.funct7),
      .imm_i        (bus.immediate),
      .imm_slots_o  (imm_slots),
      .imm_err_o    (imm_err)
   );

   always_comb begin
      raw_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      case (bus.instr_type)
         INSTR_I:          raw_word = imm_slots | {12'b0, bus.rs1, bus.funct3, bus.rd, bus.opcode};
         INSTR_S, INSTR_B: raw_word = imm_slots | {7'b0, bus.rs2, bus.rs1, bus.funct3, 5'b0, bus.opcode};
         INSTR_U, INSTR_J: raw_word = imm_slots | {20'b0, bus.rd, bus.opcode};
         default: ;
      endcase
   end

`ifdef IR_ENCODER_CHECK_EN
   logic type_op_ok;
   always_comb begin
      type_op_ok = 1'b0;
      case (bus.instr_type)
         INSTR_R: type_op_ok = (bus.opcode == OP_ALU);
         INSTR_I: type_op_ok = bus.opcode inside {OP_JALR, OP_LD, OP_ALUI, OP_ECSR, OP_FENCE};
         INSTR_S: type_op_ok = (bus.opcode == OP_ST);
         INSTR_B: type_op_ok = (bus.opcode == OP_BRANCH);
         INSTR_U: type_op_ok = bus.opcode inside {OP_LUI, OP_AUIPC};
         INSTR_J: type_op_ok = (bus.opcode == OP_JAL);
         default: type_op_ok = 1'b0;
      endcase
   end
   assign new_err = !type_op_ok || imm_err;
`else
   logic unused_imm_err;
   assign unused_imm_err = imm_err;
   assign new_err        = 1'b0;
`endif

   assign new_entry.ir  = new_err ? 32'h0000_0000 : raw_word;
   assign new_entry.err = new_err;

   assign push = bus.in_valid && in_ready_q;
   assign pop  = out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FIFO_EMPTY;
         in_ready_q <= 1'b1;
         head_q     <= '0;
         tail_q     <= '0;
         enc_q      <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != FIFO_FULL);
         head_q     <= head_d;
         tail_q     <= tail_d;
         enc_q      <= enc_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         FIFO_EMPTY: if (push) begin
            state_d = FIFO_ONE;
            head_d  = new_entry;
         end
         FIFO_ONE: begin
            if (push && pop) begin
               head_d = new_entry;
            end else if (push) begin
               state_d = FIFO_FULL;
               tail_d  = new_entry;
            end else if (pop) begin
               state_d = FIFO_EMPTY;
            end
         end
         FIFO_FULL: if (pop) begin
            state_d = FIFO_ONE;
            head_d  = tail_q;
         end
         default: state_d = FIFO_EMPTY;
      endcase
   end

   always_comb begin
      enc_d = enc_q;
      err_d = err_q;
      if (push && (enc_q != '1)) enc_d = enc_q + 1'b1;
      if (push && new_entry.err && (err_q != '1)) err_d = err_q + 1'b1;
   end

   always_comb begin
      out_valid   = (state_q != FIFO_EMPTY);
      bus.out_ir  = out_valid ? head_q.ir : 32'h0;
      bus.out_err = out_valid && head_q.err;
   end

   assign bus.out_valid = out_valid;
   assign bus.in_ready  = in_ready_q;
   assign enc_count     = enc_q;
   assign err_count     = err_q;

endmodule

// File: tb/tb_ir_encoder.sv
// Directed-vector bench for ir_encoder: encodings, error words, backpressure,
// reset while full and counter saturation (narrow counters keep the run short).
module tb_ir_encoder;
   import ir_encoder_pkg::*;

   localparam int CNT_W = 8;
`ifdef IR_ENCODER_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [CNT_W-1:0] enc_count, err_count;
   always #5 clk = ~clk;

   ir_encoder_if bus();

   ir_encoder #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .enc_count (enc_count),
      .err_count (err_count)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [CNT_W-1:0] exp_enc, exp_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   task automatic drive(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
      bus.in_valid   = 1'b1;
      bus.instr_type = t;
      bus.opcode     = op;
      bus.rd         = rd;
      bus.rs1        = rs1;
      bus.rs2        = rs2;
      bus.funct3     = f3;
      bus.funct7     = f7;
      bus.immediate  = imm;
   endtask

   // One accepted bundle with out_ready high; the word is popped on the following edge.
   task automatic send(input string tag, input logic [2:0] t, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                       input logic [31:0] exp_ir, input logic exp_e);
      @(negedge clk);
      bus.out_ready = 1'b1;
      drive(t, op, rd, rs1, rs2, f3, f7, imm);
      check({tag, ".rdy"}, {31'b0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      exp_enc = sat_inc(exp_enc);
      if (exp_e) exp_err = sat_inc(exp_err);
      check({tag, ".vld"}, {31'b0, bus.out_valid}, 32'd1);
      check({tag, ".ir"}, bus.out_ir, exp_ir);
      check({tag, ".err"}, {31'b0, bus.out_err}, {31'b0, exp_e});
      check({tag, ".enc"}, {24'b0, enc_count}, {24'b0, exp_enc});
      check({tag, ".errcnt"}, {24'b0, err_count}, {24'b0, exp_err});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus.out_ready = 1'b1;
      drive(INSTR_R, OP_ALU, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      bus.in_valid = 1'b0;
      exp_enc = '0;
      exp_err = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.vld", {31'b0, bus.out_valid}, 32'd0);
      check("rst.ir", bus.out_ir, 32'd0);
      check("rst.err", {31'b0, bus.out_err}, 32'd0);
      check("rst.rdy", {31'b0, bus.in_ready}, 32'd1);
      check("rst.enc", {24'b0, enc_count}, 32'd0);
      check("rst.errcnt", {24'b0, err_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      send("addi", INSTR_I, OP_ALUI,   5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
      send("sw",   INSTR_S, OP_ST,     5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
      send("lui",  INSTR_U, OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
      send("beq",  INSTR_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
      send("beq3", INSTR_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,
           CHK ? 32'h0 : 32'h0000_0163, CHK);
      send("rst_op", INSTR_R, OP_ST,   5'd3, 5'd4, 5'd5, 3'd0, 7'd0, 32'd0,
           CHK ? 32'h0 : 32'h0052_01A3, CHK);
      send("srai", INSTR_I, OP_ALUI,   5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd3, 32'h4031_5093, 1'b0);
      send("jal",  INSTR_J, OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_00EF, 1'b0);
      send("add",  INSTR_R, OP_ALU,    5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B3, 1'b0);
      send("terr", INSTR_ERR, OP_ALU,  5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,
           CHK ? 32'h0 : 32'h0020_81B3, CHK);
      send("ulow", INSTR_U, OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,
           CHK ? 32'h0 : 32'h0000_02B7, CHK);
      send("irng", INSTR_I, OP_ALUI,   5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800,
           CHK ? 32'h0 : 32'h8000_0093, CHK);
      send("shrng", INSTR_I, OP_ALUI,  5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'd32,
           CHK ? 32'h0 : 32'h0001_1093, CHK);

      @(posedge clk);
      #1;
      check("drain.vld", {31'b0, bus.out_valid}, 32'd0);
      check("drain.ir", bus.out_ir, 32'd0);

      // Backpressure: three back-to-back bundles with the consumer stalled.
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(INSTR_I, OP_ALUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      @(negedge clk);
      check("bp.rdy2", {31'b0, bus.in_ready}, 32'd1);
      drive(INSTR_R, OP_ALU, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
      @(negedge clk);
      check("bp.rdy3", {31'b0, bus.in_ready}, 32'd0);
      check("bp.head", bus.out_ir, 32'h0050_0093);
      drive(INSTR_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
      exp_enc = sat_inc(sat_inc(exp_enc));
      @(posedge clk);
      #1;
      check("bp.stall_ir", bus.out_ir, 32'h0050_0093);
      check("bp.stall_enc", {24'b0, enc_count}, {24'b0, exp_enc});
      @(negedge clk);
      bus.out_ready = 1'b1;
      check("bp.rdy_ignores_oready", {31'b0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("bp.pop1", bus.out_ir, 32'h0020_81B3);
      check("bp.rdy_back", {31'b0, bus.in_ready}, 32'd1);
      check("bp.enc_hold", {24'b0, enc_count}, {24'b0, exp_enc});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      exp_enc = sat_inc(exp_enc);
      check("bp.pop2", bus.out_ir, 32'h1234_52B7);
      check("bp.enc3", {24'b0, enc_count}, {24'b0, exp_enc});
      @(posedge clk);
      #1;
      check("bp.empty", {31'b0, bus.out_valid}, 32'd0);

      // Reset while FULL drops buffered words and clears counters.
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(INSTR_I, OP_ALUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      repeat (2) @(posedge clk);
      #1;
      check("rf.full", {31'b0, bus.in_ready}, 32'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rf.vld", {31'b0, bus.out_valid}, 32'd0);
      check("rf.ir", bus.out_ir, 32'd0);
      check("rf.rdy", {31'b0, bus.in_ready}, 32'd1);
      check("rf.enc", {24'b0, enc_count}, 32'd0);
      check("rf.errcnt", {24'b0, err_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Saturation: stream error-prone branches at one word per cycle.
      bus.out_ready = 1'b1;
      drive(INSTR_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
      repeat (254) @(posedge clk);
      #1;
      check("sat.enc254", {24'b0, enc_count}, 32'h0000_00FE);
      check("sat.err254", {24'b0, err_count}, CHK ? 32'h0000_00FE : 32'h0);
      @(posedge clk);
      #1;
      check("sat.enc255", {24'b0, enc_count}, 32'h0000_00FF);
      repeat (5) @(posedge clk);
      #1;
      check("sat.enc_stick", {24'b0, enc_count}, 32'h0000_00FF);
      check("sat.err_stick", {24'b0, err_count}, CHK ? 32'h0000_00FF : 32'h0);
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
